// File: rtl/iter_divider.sv
// Restoring radix-2 signed divider: one quotient bit per cycle, WIDTH iterations, then a sign fix.
// Optional remainder output enabled by defining DIV_REMAINDER_OUT_EN.
module iter_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
`ifdef DIV_REMAINDER_OUT_EN
    output logic [WIDTH-1:0] remainder,
`endif
    output logic             busy,
    output logic             result_ready,
    output logic             exception
);

    localparam int unsigned CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned W1  = WIDTH + 1;
    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] dvs_r;
    logic [CW-1:0]    cnt;
    logic             neg_q;
    logic             ovf;
`ifdef DIV_REMAINDER_OUT_EN
    logic             neg_r;
`endif

    logic [WIDTH-1:0] dvd_abs_c;
    logic [WIDTH-1:0] dvs_abs_c;
    logic             div_zero_c;
    logic [WIDTH-1:0] shifted_c;
    logic [W1-1:0]    trial_c;
    logic             last_c;

    // Operand magnitudes; INT_MIN maps onto its own bit pattern as an unsigned value.
    always_comb begin
        dvd_abs_c  = dividend[WIDTH-1] ? (WIDTH'(0) - dividend) : dividend;
        dvs_abs_c  = divisor[WIDTH-1]  ? (WIDTH'(0) - divisor)  : divisor;
        div_zero_c = (divisor == '0);
    end

    // One restoring step: shift in the next dividend bit and trial-subtract the divisor.
    always_comb begin
        shifted_c = {rem_r[WIDTH-2:0], q_r[WIDTH-1]};
        trial_c   = W1'({1'b0, shifted_c}) + W1'({1'b1, ~dvs_r}) + W1'(1);
        last_c    = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A start pulse always reloads, aborting whatever is in flight.
    always_comb begin
        state_next = state;
        if (start) begin
            state_next = div_zero_c ? DONE : RUN;
        end else begin
            case (state)
                IDLE:    state_next = IDLE;
                RUN:     state_next = last_c ? FIX : RUN;
                FIX:     state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_r          <= '0;
            rem_r        <= '0;
            dvs_r        <= '0;
            cnt          <= '0;
            neg_q        <= 1'b0;
            ovf          <= 1'b0;
            quotient     <= '0;
            busy         <= 1'b0;
            result_ready <= 1'b0;
            exception    <= 1'b0;
`ifdef DIV_REMAINDER_OUT_EN
            neg_r        <= 1'b0;
            remainder    <= '0;
`endif
        end else begin
            busy         <= (state_next != IDLE);
            result_ready <= (state == DONE);
            if (start) begin
                neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                ovf   <= (dividend == INT_MIN) && (divisor == '1);
                q_r   <= dvd_abs_c;
                dvs_r <= dvs_abs_c;
                rem_r <= '0;
                cnt   <= '0;
`ifdef DIV_REMAINDER_OUT_EN
                neg_r <= dividend[WIDTH-1];
`endif
                if (div_zero_c) begin
                    quotient  <= '0;
                    exception <= 1'b1;
`ifdef DIV_REMAINDER_OUT_EN
                    remainder <= '0;
`endif
                end
            end else if (state == RUN) begin
                rem_r <= trial_c[WIDTH] ? shifted_c : trial_c[WIDTH-1:0];
                q_r   <= {q_r[WIDTH-2:0], ~trial_c[WIDTH]};
                cnt   <= cnt + CW'(1);
            end else if (state == FIX) begin
                quotient  <= neg_q ? (WIDTH'(0) - q_r) : q_r;
                exception <= ovf;
`ifdef DIV_REMAINDER_OUT_EN
                remainder <= neg_r ? (WIDTH'(0) - rem_r) : rem_r;
`endif
            end
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider: expected results queued at issue, checked on result_ready.
module tb_iter_divider;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        result_ready;
    logic        exception;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        exc;
        int          e0;
        int          lat;
    } exp_t;

    exp_t sb[$];

    iter_divider #(.WIDTH(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .dividend     (dividend),
        .divisor      (divisor),
        .quotient     (quotient),
`ifdef DIV_REMAINDER_OUT_EN
        .remainder    (remainder),
`endif
        .busy         (busy),
        .result_ready (result_ready),
        .exception    (exception)
    );

`ifndef DIV_REMAINDER_OUT_EN
    assign remainder = '0;
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model built on the simulator's own signed division.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int signed sa;
        int signed sb_;
        sa = $signed(a);
        sb_ = $signed(b);
        e.e0 = 0;
        if (b == 32'd0) begin
            e.q = 32'd0; e.r = 32'd0; e.exc = 1'b1; e.lat = 1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000; e.r = 32'd0; e.exc = 1'b1; e.lat = 34;
        end else begin
            e.q = 32'(sa / sb_); e.r = 32'(sa % sb_); e.exc = 1'b0; e.lat = 34;
        end
        return e;
    endfunction

    // Compare every result_ready pulse against the oldest outstanding expectation.
    always @(negedge clock) begin
        if (result_ready) begin
            if (sb.size() == 0) begin
                check("spurious_ready", 32'(result_ready), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", quotient, e.q);
                check("exception", 32'(exception), 32'(e.exc));
                check("latency", 32'(cyc - e.e0), 32'(e.lat));
`ifdef DIV_REMAINDER_OUT_EN
                check("remainder", remainder, e.r);
`endif
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(negedge clock);
        e = model(a, b);
        e.e0 = cyc + 1;
        sb.push_back(e);
        start = 1'b1;
        dividend = a;
        divisor = b;
        @(negedge clock);
        start = 1'b0;
        dividend = $urandom;
        divisor = $urandom;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            check("timeout_pending", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(negedge clock);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        reset = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (3) @(negedge clock);
        check("rst_quotient", quotient, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(result_ready), 32'd0);
        check("rst_exception", 32'(exception), 32'd0);
        reset = 1'b0;

        issue(32'd100, 32'd7);
        check("busy_run", 32'(busy), 32'd1);
        wait_done();
        issue(-32'sd100, 32'd7);       wait_done();
        issue(32'd100, -32'sd7);       wait_done();
        issue(-32'sd100, -32'sd7);     wait_done();

        issue(32'd55, 32'd0);
        check("dz_busy_first", 32'(busy), 32'd1);
        @(negedge clock);
        check("dz_busy_second", 32'(busy), 32'd0);
        wait_done();

        issue(32'h8000_0000, 32'hFFFF_FFFF); wait_done();
        issue(32'h8000_0000, 32'd1);         wait_done();
        issue(32'd0, 32'd5);                 wait_done();
        issue(32'h7FFF_FFFF, 32'h8000_0000); wait_done();

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = 32'($signed($urandom) >>> $urandom_range(0, 30));
            issue(ra, rb);
            wait_done();
        end

        // Start landing on the DONE edge: old result still pulses, new one loads.
        issue(32'd77, 32'd5);
        repeat (32) @(negedge clock);
        issue(-32'sd81, 32'd4);
        wait_done();

        // Restart mid-operation: only the second operation reports.
        issue(32'd1000, 32'd3);
        repeat (8) @(negedge clock);
        void'(sb.pop_back());
        issue(32'd9, 32'd2);
        wait_done();

        // Reset mid-operation clears everything with no later result.
        issue(32'd50, 32'd5);
        repeat (18) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        sb.delete();
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_ready", 32'(result_ready), 32'd0);
        check("rstmid_quotient", quotient, 32'd0);
        check("rstmid_exception", 32'(exception), 32'd0);
        repeat (50) @(negedge clock);
        check("rstmid_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
